// File: rtl/syscall_pkg.sv
// Shared definitions for the SYSCALL responder: service codes and FSM state encoding.
package syscall_pkg;

   localparam logic [31:0] SYS_PRINT_INT = 32'd1;
   localparam logic [31:0] SYS_PRINT_HEX = 32'd34;
   localparam logic [31:0] SYS_EXIT      = 32'd10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_FIRE,
      ST_RELEASE,
      ST_EXIT
   } sys_state_t;

endpackage

// File: rtl/syscall_responder_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, and a one-cycle
// pulse on each debounced 0->1 transition.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic clk,
   input  logic CLR,
   input  logic btn,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          level_reg;
   logic          level_d_reg;
   logic          rise_reg;
   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (CLR) begin
         sync1_reg   <= 1'b0;
         sync2_reg   <= 1'b0;
         level_reg   <= 1'b0;
         level_d_reg <= 1'b0;
         rise_reg    <= 1'b0;
         cnt_reg     <= '0;
      end else begin
         sync1_reg   <= btn;
         sync2_reg   <= sync1_reg;
         level_d_reg <= level_reg;
         rise_reg    <= level_reg & ~level_d_reg;
         // Any sample agreeing with the accepted level restarts the stability window.
         if (sync2_reg != level_reg) begin
            if (cnt_reg == CW'(DEBOUNCE_CYC - 1)) begin
               level_reg <= sync2_reg;
               cnt_reg   <= '0;
            end else begin
               cnt_reg <= cnt_reg + CW'(1);
            end
         end else begin
            cnt_reg <= '0;
         end
      end
   end

   assign rise = rise_reg;

endmodule

// File: rtl/syscall_responder.sv
// Services pipeline SYSCALL halts: print to display, exit, or no-op, then pulses GO.
// Optional macro SYSCALL_AUTO_GO_EN adds a timed automatic resume from WAIT.
module syscall_responder
   import syscall_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 16,
   parameter int AUTO_DELAY   = 8,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             CLR,
   input  logic             halt,
   input  logic [31:0]      v0,
   input  logic [31:0]      a0,
   input  logic             btn,
   output logic             GO,
   output logic [31:0]      display,
   output logic             exited,
   output logic [CNT_W-1:0] sys_cnt
);

   sys_state_t state_reg;
   logic       btn_rise;
   logic       resume;

   btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
   ) u_btn_debounce (
      .clk (clk),
      .CLR (CLR),
      .btn (btn),
      .rise(btn_rise)
   );

`ifdef SYSCALL_AUTO_GO_EN
   localparam int AW = $clog2(AUTO_DELAY + 2);
   logic [AW-1:0] auto_cnt_reg;
   assign resume = btn_rise | (auto_cnt_reg == '0);
`else
   assign resume = btn_rise;
`endif

   always_ff @(posedge clk) begin
      if (CLR) begin
         state_reg <= ST_IDLE;
         GO        <= 1'b0;
         display   <= '0;
         exited    <= 1'b0;
         sys_cnt   <= '0;
`ifdef SYSCALL_AUTO_GO_EN
         auto_cnt_reg <= '0;
`endif
      end else begin
         GO <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (halt) begin
                  if (sys_cnt != '1) sys_cnt <= sys_cnt + CNT_W'(1);
                  case (v0)
                     SYS_PRINT_INT, SYS_PRINT_HEX: begin
                        display   <= a0;
                        state_reg <= ST_WAIT;
`ifdef SYSCALL_AUTO_GO_EN
                        auto_cnt_reg <= AW'(AUTO_DELAY);
`endif
                     end
                     SYS_EXIT: begin
                        exited    <= 1'b1;
                        state_reg <= ST_EXIT;
                     end
                     default: begin
                        GO        <= 1'b1;
                        state_reg <= ST_FIRE;
                     end
                  endcase
               end
            end
            ST_WAIT: begin
               if (resume) begin
                  GO        <= 1'b1;
                  state_reg <= ST_FIRE;
               end
`ifdef SYSCALL_AUTO_GO_EN
               else begin
                  auto_cnt_reg <= auto_cnt_reg - AW'(1);
               end
`endif
            end
            ST_FIRE:    state_reg <= ST_RELEASE;
            // Held halt after GO belongs to the request just serviced.
            ST_RELEASE: if (!halt) state_reg <= ST_IDLE;
            ST_EXIT:    state_reg <= ST_EXIT;
            default:    state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/syscall_responder.md
# syscall_responder

Services SYSCALL requests raised by the five-stage pipeline's syscall control. When the pipeline halts on a SYSCALL, this block:
- latches the service code and argument;
- updates the board display or terminates the program;
- returns a single-cycle `GO` pulse that releases the pipeline.

It sits at the top level between the pipeline's halt/register outputs and the board's display and push-button.

## Interface
Parameters:
- `DEBOUNCE_CYC`, default 16: cycles the raw button must stay stable before an edge is accepted.
- `AUTO_DELAY`, default 8: cycles in WAIT before an automatic resume (only when `SYSCALL_AUTO_GO_EN` is defined).
- `CNT_W`, default 16: width of the serviced-syscall counter.

Ports:
- `clk` in 1: the single clock.
- `CLR` in 1: synchronous, active-high reset.
- `halt` in 1: level from the pipeline. High while a SYSCALL is held in WB.
- `v0` in 32: service code (`$v0` read in WB).
- `a0` in 32: argument (`$a0` read in WB).
- `btn` in 1: raw, asynchronous resume push-button.
- `GO` out 1: one-cycle resume pulse to the pipeline.
- `display` out 32: last printed value.
- `exited` out 1: high after the exit service, sticky until `CLR`.
- `sys_cnt` out `CNT_W`: number of serviced syscalls, saturating.

## Operation
- Service codes are compared on all 32 bits:
  - 1 = print integer.
  - 34 = print hex.
  - 10 = exit.
  - Any other value = no-op.
- Print (1 or 34): `display <= a0`. The block then waits for a resume event.
- Exit (10): `exited <= 1`. `GO` is never issued, so the pipeline stays halted until `CLR`.
- No-op: the block resumes immediately and `display` is unchanged.
- Resume event:
  - Without the macro: a debounced rising edge of `btn`.
  - With the macro: see Configuration.
- FSM states: IDLE, WAIT, FIRE, RELEASE, EXIT.
  - IDLE, `halt` = 1: capture `v0`/`a0` and increment `sys_cnt`. Then go to WAIT (print), FIRE (no-op) or EXIT (exit).
  - WAIT, resume event: go to FIRE.
  - FIRE: `GO` = 1 for exactly this cycle. Then go to RELEASE.
  - RELEASE: stay while `halt` = 1. Go to IDLE once `halt` = 0. This guarantees one request produces exactly one service.
  - EXIT: terminal state. Only `CLR` leaves it.
- `sys_cnt` saturates at all-ones and does not wrap.
- A `btn` edge that occurs while not in WAIT is discarded; it is not queued.
- `CLR` asserted in any state:
  - FSM returns to IDLE.
  - `GO` = 0, `display` = 0, `exited` = 0, `sys_cnt` = 0.
  - Debouncer state is cleared.

## Timing
- All outputs are registered.
- Reset values: `GO` = 0, `display` = 0, `exited` = 0, `sys_cnt` = 0. FSM = IDLE.
- Cycle N is the first clock edge that samples `halt` = 1 in IDLE:
  - `display`, `exited` and `sys_cnt` update at edge N.
  - No-op: `GO` is high during cycle N+1.
  - Print: `GO` is high during the cycle after the resume event is recognised.
- Button path: a 2-flop synchroniser, then a `DEBOUNCE_CYC` stability counter.
  - Edge latency from `btn` change to a recognised event is `DEBOUNCE_CYC` + 3 cycles.
  - The rising edge is recognised when the debounced level changes 0→1.
- `halt` is level-sensitive. It is held high after `GO` until the pipeline restarts, which the RELEASE state absorbs.
- A `halt` that rises in the same cycle RELEASE exits is first sampled in IDLE on the next edge.
- Minimum spacing between two services is 3 cycles (no-op back-to-back).

## Configuration
- Macro: `SYSCALL_AUTO_GO_EN`.
- Defined:
  - WAIT loads a down-counter with `AUTO_DELAY`.
  - The resume event is the counter reaching 0 or a debounced `btn` edge, whichever comes first.
  - For simulation and unattended runs.
- Undefined:
  - Only the debounced `btn` edge resumes.
  - The counter logic is absent.

## Structure
- Shared package `syscall_pkg` holds:
  - service-code constants `SYS_PRINT_INT` = 32'd1, `SYS_PRINT_HEX` = 32'd34, `SYS_EXIT` = 32'd10;
  - the state enum `sys_state_t`.
- One sub-module, `btn_debounce`: synchroniser, stability counter and rising-edge pulse output. Parameter `DEBOUNCE_CYC`; ports `clk`, `CLR`, `btn`, `rise`.

## Test plan
- Reset then idle: hold `halt` = 0 for 20 cycles → `GO` = 0, `display` = 0, `sys_cnt` = 0 throughout.
- Print, button resume (macro off): `v0` = 1, `a0` = 32'hDEAD_BEEF, `halt` = 1 → `display` = 32'hDEADBEEF at the next edge; no `GO` for 100 cycles. Then press `btn` stable for 20 cycles → exactly one `GO` pulse; `sys_cnt` = 1.
- No-op: `v0` = 5, `halt` held high for 6 cycles → one `GO` one cycle after capture; `display` unchanged; no second `GO` while `halt` remains high.
- Exit: `v0` = 10 → `exited` = 1 and `GO` never asserted. Press `btn` → still no `GO`. `CLR` → `exited` = 0, FSM returns to IDLE.
- Bounce and stray press: toggle `btn` every 3 cycles (`DEBOUNCE_CYC` = 16) → no event. Press `btn` while IDLE, then issue a print → WAIT is still held and no `GO` is issued.
- Auto resume (macro on, `AUTO_DELAY` = 8): print `v0` = 34 → `GO` in the cycle after the counter expires. `CLR` mid-WAIT → no `GO`, `display` = 0.
